// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8-entry register file with writeback bypass and a
// single-entry valid/ready output register feeding the ALU.
module operand_fetch #(
  parameter int n    = 8,
  parameter int REGS = 8,
  localparam int AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [n-1:0]  imm,
  input  logic          use_imm,
  input  logic [3:0]    func_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  a,
  output logic [n-1:0]  b,
  output logic [3:0]    func,
  output logic [AW-1:0] rd_out,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [n-1:0]  wb_data
);

  logic [REGS-1:0][n-1:0] r_rf;
  logic                   r_valid;
  logic [n-1:0]           r_a, r_b;
  logic [3:0]             r_func;
  logic [AW-1:0]          r_rd, r_rs, r_rt;
  logic                   r_use_imm;

  logic                   w_accept;
  logic                   w_wb_live;
  logic [n-1:0]           w_rs_val, w_rt_val, w_b_sel;

  // A writeback to R0 is dropped everywhere, so fold that into one qualifier.
  assign w_wb_live = wb_en && (wb_addr != '0);
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // Register read with write-before-read bypass; R0 is hardwired to zero.
  always_comb begin
    w_rs_val = '0;
    w_rt_val = '0;
    if (rs_addr != '0)
      w_rs_val = (w_wb_live && wb_addr == rs_addr) ? wb_data : r_rf[rs_addr];
    if (rt_addr != '0)
      w_rt_val = (w_wb_live && wb_addr == rt_addr) ? wb_data : r_rf[rt_addr];
    w_b_sel = use_imm ? imm : w_rt_val;
  end

  // Register file write port; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (reset)
      r_rf <= '0;
    else if (w_wb_live)
      r_rf[wb_addr] <= wb_data;
  end

  // Output stage: load on accept, drop on consume, refresh held operands
  // from a matching writeback while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_func    <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_use_imm <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_a       <= w_rs_val;
      r_b       <= w_b_sel;
      r_func    <= func_in;
      r_rd      <= rd_addr;
      r_rs      <= rs_addr;
      r_rt      <= rt_addr;
      r_use_imm <= use_imm;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid && w_wb_live) begin
      if (wb_addr == r_rs)
        r_a <= wb_data;
      if (!r_use_imm && wb_addr == r_rt)
        r_b <= wb_data;
    end
  end

  assign out_valid = r_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign func      = r_func;
  assign rd_out    = r_rd;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the picoMIPS datapath, sitting directly upstream of the ALU. It holds the 8-entry register file and selects a register or immediate for the second operand. It registers `a`, `b`, `func` and the destination address into a single-entry output stage with a valid/ready handshake. It also accepts the writeback of ALU results and bypasses them into operands being captured or held.

## Interface
Parameters:
- `n`, 8, datapath width; matches ALU operand width
- `REGS`, 8, register count; address width is `$clog2(REGS)` (3 at default)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage can accept an instruction this cycle
- `rs_addr`  in  3  source register for operand `a`
- `rt_addr`  in  3  source register for operand `b` when `use_imm`=0
- `rd_addr`  in  3  destination register, passed through
- `imm`  in  n  immediate for operand `b`
- `use_imm`  in  1  1: `b`=`imm`; 0: `b`=R[`rt_addr`]
- `func_in`  in  4  ALU function code, passed through unmodified
- `out_valid`  out  1  `a`/`b`/`func`/`rd_out` hold a valid instruction
- `out_ready`  in  1  ALU/writeback consumes the output this cycle
- `a`, `b`  out  n  registered ALU operands (signed two's complement)
- `func`  out  4  registered function code
- `rd_out`  out  3  registered destination address
- `wb_en`  in  1  write `wb_data` to R[`wb_addr`]
- `wb_addr`  in  3  writeback address
- `wb_data`  in  n  writeback value (ALU `result`)

## Operation
- **Register file:** `REGS` x `n`, all entries cleared on reset.
  - R0 reads 0 always; writes to R0 are ignored.
  - Write occurs on the clock edge with `wb_en`=1.
- **Read with bypass (write-before-read):** when capturing, if `wb_en`=1 and `wb_addr`==`rs_addr`!=0, the captured `a` is `wb_data`, not the stale entry. The same rule applies to `rt_addr`/`b` when `use_imm`=0.
- **Handshake:**
  - `in_ready` = !`out_valid` | `out_ready` (combinational).
  - Accept = `in_valid` & `in_ready`.
  - On accept: `a`, `b`, `func`, `rd_out` load; `out_valid`<=1; the entry's `rs`, `rt` and `use_imm` are stored internally.
  - No accept and `out_ready`=1: `out_valid`<=0; data regs keep their value.
  - No accept and `out_ready`=0: hold.
- **Held-operand refresh:** while `out_valid`=1 and `out_ready`=0, a writeback with `wb_en`=1 updates the held operands:
  - `wb_addr`==stored rs!=0 reloads `a` with `wb_data`.
  - `wb_addr`==stored rt!=0 with stored `use_imm`=0 reloads `b` with `wb_data`.
  - The register file write happens as well.
- **Function code:** `func` is never decoded here. ALU semantics (e.g. SUB = `b`-`a`, MUL = Q1.7 product) are the ALU's concern, so operand order is fixed: `a` from rs, `b` from rt/imm.
- **Simultaneous accept and consume:** the new entry replaces the old one and `out_valid` stays 1. This gives full throughput of 1 instruction/cycle.
- **Reset:** asserting `reset` mid-operation discards any held entry in the cycle it is sampled; the register file clears in the same cycle.

## Timing
- **Reset values:** `out_valid`=0, `a`=0, `b`=0, `func`=0, `rd_out`=0, all registers 0. `in_ready`=1 from the first cycle after reset.
- **Latency:** instruction accepted at edge k is presented on `a`/`b` from edge k (visible in cycle k+1) until consumed.
- **Writeback visibility:** a writeback at edge k is visible to a capture at that same edge (bypass) and to all later reads.
- **Back-pressure:** `in_ready` falls in the same cycle that `out_valid`=1 and `out_ready`=0; no internal buffering beyond one entry.
- **Output stability:** outputs change only on accept, refresh or reset, never while stalled without a matching writeback.

## Test plan
- **Reset:** reset for 2 cycles then release -> `out_valid`=0, `a`=`b`=0, `in_ready`=1; read of every register returns 0.
- **Write then read:** write R3=0x25 (`wb_en`), next cycle issue rs=3, `use_imm`=1, `imm`=0x10, `func_in`=ADD -> next cycle `a`=0x25, `b`=0x10, `func`=ADD, `out_valid`=1.
- **Same-edge bypass:** in the same cycle, `wb_en` with R5=0x7F and an issue of rs=5, rt=5, `use_imm`=0 -> `a`=`b`=0x7F. Separately, R0 write 0x55 then read rs=0 -> `a`=0.
- **Stall and refresh:** issue rs=2 (R2=0x01) with `out_ready`=0, then writeback R2=0x80 -> `a` becomes 0x80 and `in_ready`=0 while stalled. Raise `out_ready` -> consumed, then `out_valid`=0.
- **Back-to-back throughput:** 4 instructions with `in_valid`=`out_ready`=1 continuously -> one output per cycle, in order, `out_valid` never drops.
- **Reset mid-stall:** `out_valid`=1, `out_ready`=0, assert `reset` for 1 cycle -> `out_valid`=0 and R2 reads 0 afterwards.
